// File: rtl/dma_mc_engine_pkg.sv
// Shared types and default sizing for the multi-channel DMA engine.
// Contents: default parameter values and the engine FSM state encoding.
package dma_mc_engine_pkg;

  localparam int unsigned NumChDef = 4;
  localparam int unsigned ChWDef   = 2;
  localparam int unsigned AddrWDef = 16;
  localparam int unsigned DataWDef = 32;
  localparam int unsigned SizeWDef = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArb  = 2'd1,
    StRd   = 2'd2,
    StWr   = 2'd3
  } state_e;

endpackage

// File: rtl/dma_mc_engine_if.sv
// Bus bundle between the DMA engine and the core / SRAM.
// master: engine side (takes kicks, drives the SRAM port and status).
// slave : core side (issues kicks, owns mem_hold, returns SRAM read data).
// Signals: kick/kick_ch/kick_src/kick_dst/kick_size, kick_err, mem_hold,
//          sram_addr/sram_di/sram_en/sram_we/sram_do, ch_busy, ch_done, any_busy.
interface dma_mc_engine_if
  import dma_mc_engine_pkg::*;
#(
  parameter int unsigned NumCh = NumChDef,
  parameter int unsigned ChW   = ChWDef,
  parameter int unsigned AddrW = AddrWDef,
  parameter int unsigned DataW = DataWDef,
  parameter int unsigned SizeW = SizeWDef
) ();

  logic             kick;
  logic [ChW-1:0]   kick_ch;
  logic [AddrW-1:0] kick_src;
  logic [AddrW-1:0] kick_dst;
  logic [SizeW-1:0] kick_size;
  logic             kick_err;
  logic             mem_hold;
  logic [AddrW-1:0] sram_addr;
  logic [DataW-1:0] sram_di;
  logic             sram_en;
  logic             sram_we;
  logic [DataW-1:0] sram_do;
  logic [NumCh-1:0] ch_busy;
  logic [NumCh-1:0] ch_done;
  logic             any_busy;

  modport master (
    input  kick, kick_ch, kick_src, kick_dst, kick_size, mem_hold, sram_do,
    output kick_err, sram_addr, sram_di, sram_en, sram_we, ch_busy, ch_done, any_busy
  );

  modport slave (
    output kick, kick_ch, kick_src, kick_dst, kick_size, mem_hold, sram_do,
    input  kick_err, sram_addr, sram_di, sram_en, sram_we, ch_busy, ch_done, any_busy
  );

endinterface

// File: rtl/dma_mc_engine_rr_arbiter.sv
// Combinational round-robin picker.
// req_i   : per-channel request (busy) vector
// rr_ptr_i: first channel to consider; search wraps at NumCh
// grant_o : index of the chosen channel, valid_o: at least one request
module dma_mc_engine_rr_arbiter
  import dma_mc_engine_pkg::*;
#(
  parameter int unsigned NumCh = NumChDef,
  parameter int unsigned ChW   = ChWDef
) (
  input  logic [NumCh-1:0] req_i,
  input  logic [ChW-1:0]   rr_ptr_i,
  output logic [ChW-1:0]   grant_o,
  output logic             valid_o
);

  logic [ChW-1:0] idx;

  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NumCh; i++) begin
      idx = ChW'((32'(rr_ptr_i) + i) % NumCh);
      if (!valid_o && req_i[idx]) begin
        valid_o = 1'b1;
        grant_o = idx;
      end
    end
  end

endmodule

// File: rtl/dma_mc_engine.sv
// Multi-channel memory-to-memory DMA engine sharing one SRAM port.
// clk/reset: rising-edge clock, asynchronous active-high reset.
// bus (master): descriptor kicks in, kick_err out, mem_hold in, SRAM port out
//               (read data in), per-channel busy/done and any_busy out.
// One word moves per ARB->RD->WR round; channels are served round-robin.
module dma_mc_engine
  import dma_mc_engine_pkg::*;
#(
  parameter int unsigned NumCh = NumChDef,
  parameter int unsigned ChW   = ChWDef,
  parameter int unsigned AddrW = AddrWDef,
  parameter int unsigned DataW = DataWDef,
  parameter int unsigned SizeW = SizeWDef
) (
  input logic            clk,
  input logic            reset,
  dma_mc_engine_if.master bus
);

  logic [AddrW-1:0] src_q [NumCh];
  logic [AddrW-1:0] src_d [NumCh];
  logic [AddrW-1:0] dst_q [NumCh];
  logic [AddrW-1:0] dst_d [NumCh];
  logic [SizeW-1:0] rem_q [NumCh];
  logic [SizeW-1:0] rem_d [NumCh];
  logic [NumCh-1:0] busy_q, busy_d;
  logic [NumCh-1:0] done_q, done_d;
  logic             kick_err_q, kick_err_d;
  state_e           state_q, state_d;
  logic [ChW-1:0]   ch_q, ch_d;
  logic [ChW-1:0]   rr_q, rr_d;

  logic [ChW-1:0]   grant;
  logic             grant_vld;
  logic             kick_in_range;
  logic             kick_ok;
  logic             kick_go;

  dma_mc_engine_rr_arbiter #(
    .NumCh (NumCh),
    .ChW   (ChW)
  ) u_arb (
    .req_i    (busy_q),
    .rr_ptr_i (rr_q),
    .grant_o  (grant),
    .valid_o  (grant_vld)
  );

  assign kick_in_range = {1'b0, bus.kick_ch} < (ChW + 1)'(NumCh);
  // busy_q is the pre-edge value, so a channel finishing in this WR still refuses the kick
  assign kick_ok = bus.kick && kick_in_range && !busy_q[bus.kick_ch];
  assign kick_go = kick_ok && (bus.kick_size != '0);

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    rr_d       = rr_q;
    src_d      = src_q;
    dst_d      = dst_q;
    rem_d      = rem_q;
    busy_d     = busy_q;
    done_d     = '0;
    kick_err_d = bus.kick && !kick_ok;

    unique case (state_q)
      // A fresh kick heads straight to ARB so the first RD lands 2 cycles after it
      StIdle: if ((|busy_q) || kick_go) state_d = StArb;
      StArb: begin
        if (!(|busy_q) && !kick_go) begin
          state_d = StIdle;
        end else if (!bus.mem_hold && grant_vld) begin
          ch_d    = grant;
          state_d = StRd;
        end
      end
      StRd: state_d = StWr;
      StWr: begin
        src_d[ch_q] = src_q[ch_q] + AddrW'(1);
        dst_d[ch_q] = dst_q[ch_q] + AddrW'(1);
        rem_d[ch_q] = rem_q[ch_q] - SizeW'(1);
        rr_d        = (32'(ch_q) == NumCh - 1) ? '0 : ch_q + ChW'(1);
        if (rem_q[ch_q] == SizeW'(1)) begin
          busy_d[ch_q] = 1'b0;
          done_d[ch_q] = 1'b1;
        end
        state_d = StArb;
      end
      default: state_d = StIdle;
    endcase

    // Never collides with the WR update above: that channel is busy, so kick_ok is low
    if (kick_ok) begin
      src_d[bus.kick_ch] = bus.kick_src;
      dst_d[bus.kick_ch] = bus.kick_dst;
      rem_d[bus.kick_ch] = bus.kick_size;
      if (bus.kick_size == '0) done_d[bus.kick_ch] = 1'b1;
      else                     busy_d[bus.kick_ch] = 1'b1;
    end
  end

  // SRAM drive is purely state-decoded so reset zeroes it without waiting for an edge
  always_comb begin
    bus.sram_en   = 1'b0;
    bus.sram_we   = 1'b0;
    bus.sram_addr = '0;
    bus.sram_di   = '0;
    unique case (state_q)
      StRd: begin
        bus.sram_en   = 1'b1;
        bus.sram_addr = src_q[ch_q];
      end
      StWr: begin
        bus.sram_en   = 1'b1;
        bus.sram_we   = 1'b1;
        bus.sram_addr = dst_q[ch_q];
        bus.sram_di   = bus.sram_do;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ch_q       <= '0;
      rr_q       <= '0;
      src_q      <= '{default: '0};
      dst_q      <= '{default: '0};
      rem_q      <= '{default: '0};
      busy_q     <= '0;
      done_q     <= '0;
      kick_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      rr_q       <= rr_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      kick_err_q <= kick_err_d;
    end
  end

  assign bus.kick_err = kick_err_q;
  assign bus.ch_busy  = busy_q;
  assign bus.ch_done  = done_q;
  assign bus.any_busy = |busy_q;

endmodule

// File: tb/tb_dma_mc_engine.sv
// Self-checking bench for dma_mc_engine. A negedge monitor logs SRAM reads, writes and
// done pulses as events; each scenario pushes the events it expects and compares them in order.
module tb_dma_mc_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dma_mc_engine_if #(.NumCh(4), .ChW(2), .AddrW(16), .DataW(32), .SizeW(16)) bus ();

  dma_mc_engine #(.NumCh(4), .ChW(2), .AddrW(16), .DataW(32), .SizeW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // SRAM model with a bench preload port
  logic [31:0] mem [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  always @(posedge clk) begin
    if (bus.sram_en && !bus.sram_we) bus.sram_do <= mem[bus.sram_addr];
    if (bus.sram_en && bus.sram_we) mem[bus.sram_addr] <= bus.sram_di;
    else if (pl_en) mem[pl_addr] <= pl_data;
  end

  function automatic logic [63:0] mk_ev(input logic [1:0] t, input logic [15:0] a,
                                         input logic [31:0] d);
    return {t, 14'b0, a, d};
  endfunction

  // Monitor: only this block writes the observation queues
  logic [63:0] obs_ev [$];
  int          obs_cyc [$];
  int          cyc = 0;
  int          hold_viol = 0;
  logic        hold_prev = 1'b0;
  logic [3:0]  busy_seen = '0;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!reset) begin
      if (bus.sram_en && !bus.sram_we) begin
        obs_ev.push_back(mk_ev(2'd1, bus.sram_addr, 32'h0));
        obs_cyc.push_back(cyc);
        if (hold_prev) hold_viol = hold_viol + 1;
      end
      if (bus.sram_en && bus.sram_we) begin
        obs_ev.push_back(mk_ev(2'd2, bus.sram_addr, bus.sram_di));
        obs_cyc.push_back(cyc);
      end
      if (bus.ch_done != '0) begin
        obs_ev.push_back(mk_ev(2'd3, 16'h0, {28'h0, bus.ch_done}));
        obs_cyc.push_back(cyc);
      end
      busy_seen = busy_seen | bus.ch_busy;
    end
    hold_prev = bus.mem_hold;
  end

  int          n_checks = 0;
  int          n_fail = 0;
  int          obs_idx = 0;
  logic [63:0] exp_q [$];

  task automatic preload(input logic [15:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Called at posedge+1; kick is presented for exactly one cycle
  task automatic do_kick(input int ch, input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] n, output logic err, output int kcyc);
    bus.kick = 1'b1; bus.kick_ch = 2'(ch); bus.kick_src = s; bus.kick_dst = d;
    bus.kick_size = n;
    kcyc = cyc + 1;
    @(posedge clk); #1;
    bus.kick = 1'b0;
    err = bus.kick_err;
  endtask

  task automatic wait_quiet(input int budget, output bit ok);
    int q;
    q = 0; ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (!bus.any_busy && !bus.sram_en && bus.ch_done == '0) q++;
      else q = 0;
      if (q >= 3) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.sram_en, bus.sram_we, bus.kick_err, bus.any_busy} !== 4'b0) begin
      n_fail++;
      $display("FAIL rst_ctrl: got %b, required 0000",
               {bus.sram_en, bus.sram_we, bus.kick_err, bus.any_busy});
    end
    n_checks++;
    if (bus.sram_addr !== 16'h0 || bus.sram_di !== 32'h0) begin
      n_fail++; $display("FAIL rst_bus: got %h/%h, required 0/0", bus.sram_addr, bus.sram_di);
    end
    n_checks++;
    if (bus.ch_busy !== 4'h0 || bus.ch_done !== 4'h0) begin
      n_fail++; $display("FAIL rst_ch: got %b/%b, required 0/0", bus.ch_busy, bus.ch_done);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.any_busy !== 1'b0 || bus.sram_en !== 1'b0) begin
      n_fail++; $display("FAIL rst_idle: got %b%b, required 00", bus.any_busy, bus.sram_en);
    end
  endtask

  task automatic test_single();
    logic [31:0] v [4];
    logic [63:0] e;
    logic        err;
    int          kc, base;
    bit          ok;
    base = obs_idx;
    for (int i = 0; i < 4; i++) begin
      v[i] = $urandom;
      preload(16'h0010 + 16'(i), v[i]);
      exp_q.push_back(mk_ev(2'd1, 16'h0010 + 16'(i), 32'h0));
      exp_q.push_back(mk_ev(2'd2, 16'h0040 + 16'(i), v[i]));
    end
    exp_q.push_back(mk_ev(2'd3, 16'h0, 32'h1));
    do_kick(0, 16'h0010, 16'h0040, 16'd4, err, kc);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL t1_kick_err: got %b, required 0", err); end
    wait_quiet(200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL t1_timeout: got busy, required idle"); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_idx >= obs_ev.size()) begin
        n_fail++; $display("FAIL t1_seq: got nothing, required %h", e);
      end else begin
        if (obs_ev[obs_idx] !== e) begin
          n_fail++; $display("FAIL t1_seq[%0d]: got %h, required %h", obs_idx - base,
                             obs_ev[obs_idx], e);
        end
        obs_idx++;
      end
    end
    n_checks++;
    if (obs_idx != obs_ev.size()) begin
      n_fail++; $display("FAIL t1_extra: got %0d extra events, required 0", obs_ev.size() - obs_idx);
      obs_idx = obs_ev.size();
    end
    if (obs_cyc.size() >= base + 9) begin
      n_checks++;
      if (obs_cyc[base] != kc + 2) begin
        n_fail++; $display("FAIL t1_first_rd: got cycle %0d, required %0d", obs_cyc[base], kc + 2);
      end
      // Done pulse is the 12th cycle counting the first RD cycle as the 1st
      n_checks++;
      if (obs_cyc[base + 8] != obs_cyc[base] + 11) begin
        n_fail++; $display("FAIL t1_done_lat: got cycle %0d, required %0d", obs_cyc[base + 8],
                           obs_cyc[base] + 11);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem[16'h0040 + 16'(i)] !== v[i]) begin
        n_fail++; $display("FAIL t1_mem[%0d]: got %h, required %h", i, mem[16'h0040 + 16'(i)], v[i]);
      end
    end
  endtask

  task automatic test_two_channels();
    logic [31:0] v1 [6];
    logic [31:0] v2 [2];
    int          ord [8];
    int          i1, i2, kc, base;
    logic [63:0] e;
    logic        err1, err2;
    bit          ok;
    base = obs_idx;
    ord = '{1, 2, 1, 2, 1, 1, 1, 1};
    for (int i = 0; i < 6; i++) begin v1[i] = $urandom; preload(16'h0100 + 16'(i), v1[i]); end
    for (int i = 0; i < 2; i++) begin v2[i] = $urandom; preload(16'h0300 + 16'(i), v2[i]); end
    i1 = 0; i2 = 0;
    for (int k = 0; k < 8; k++) begin
      if (ord[k] == 1) begin
        exp_q.push_back(mk_ev(2'd1, 16'h0100 + 16'(i1), 32'h0));
        exp_q.push_back(mk_ev(2'd2, 16'h0200 + 16'(i1), v1[i1]));
        i1++;
      end else begin
        exp_q.push_back(mk_ev(2'd1, 16'h0300 + 16'(i2), 32'h0));
        exp_q.push_back(mk_ev(2'd2, 16'h0400 + 16'(i2), v2[i2]));
        i2++;
      end
      if (k == 3) exp_q.push_back(mk_ev(2'd3, 16'h0, 32'h4));
    end
    exp_q.push_back(mk_ev(2'd3, 16'h0, 32'h2));
    do_kick(1, 16'h0100, 16'h0200, 16'd6, err1, kc);
    do_kick(2, 16'h0300, 16'h0400, 16'd2, err2, kc);
    n_checks++;
    if ({err1, err2} !== 2'b00) begin
      n_fail++; $display("FAIL t2_kick_err: got %b, required 00", {err1, err2});
    end
    wait_quiet(300, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL t2_timeout: got busy, required idle"); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_idx >= obs_ev.size()) begin
        n_fail++; $display("FAIL t2_seq: got nothing, required %h", e);
      end else begin
        if (obs_ev[obs_idx] !== e) begin
          n_fail++; $display("FAIL t2_seq[%0d]: got %h, required %h", obs_idx - base,
                             obs_ev[obs_idx], e);
        end
        obs_idx++;
      end
    end
    n_checks++;
    if (obs_idx != obs_ev.size()) begin
      n_fail++; $display("FAIL t2_extra: got %0d extra events, required 0", obs_ev.size() - obs_idx);
      obs_idx = obs_ev.size();
    end
  endtask

  task automatic test_mem_hold();
    logic [31:0] v [3];
    logic [63:0] e;
    logic        err;
    int          kc, base, nrd;
    bit          ok;
    base = obs_idx;
    for (int i = 0; i < 3; i++) begin
      v[i] = $urandom;
      preload(16'h0500 + 16'(i), v[i]);
      exp_q.push_back(mk_ev(2'd1, 16'h0500 + 16'(i), 32'h0));
      exp_q.push_back(mk_ev(2'd2, 16'h0600 + 16'(i), v[i]));
    end
    exp_q.push_back(mk_ev(2'd3, 16'h0, 32'h1));
    do_kick(0, 16'h0500, 16'h0600, 16'd3, err, kc);
    for (int i = 0; i < 10 && !(bus.sram_en && !bus.sram_we); i++) begin
      @(posedge clk); #1;
    end
    // Raised during the first RD: that RD/WR pair must still complete
    bus.mem_hold = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    nrd = 0;
    for (int i = base; i < obs_ev.size(); i++) if (obs_ev[i][63:62] == 2'd1) nrd++;
    n_checks++;
    if (nrd != 1) begin n_fail++; $display("FAIL t3_rd_during_hold: got %0d reads, required 1", nrd); end
    n_checks++;
    if (bus.any_busy !== 1'b1) begin
      n_fail++; $display("FAIL t3_busy_hold: got %b, required 1", bus.any_busy);
    end
    bus.mem_hold = 1'b0;
    wait_quiet(200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL t3_timeout: got busy, required idle"); end
    n_checks++;
    if (hold_viol != 0) begin n_fail++; $display("FAIL t3_hold_viol: got %0d, required 0", hold_viol); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_idx >= obs_ev.size()) begin
        n_fail++; $display("FAIL t3_seq: got nothing, required %h", e);
      end else begin
        if (obs_ev[obs_idx] !== e) begin
          n_fail++; $display("FAIL t3_seq[%0d]: got %h, required %h", obs_idx - base,
                             obs_ev[obs_idx], e);
        end
        obs_idx++;
      end
    end
    n_checks++;
    if (obs_idx != obs_ev.size()) begin
      n_fail++; $display("FAIL t3_extra: got %0d extra events, required 0", obs_ev.size() - obs_idx);
      obs_idx = obs_ev.size();
    end
  endtask

  task automatic test_busy_and_zero();
    logic [31:0] v [5];
    logic [63:0] e;
    logic        err0, err1, err3;
    int          kc, base;
    bit          ok;
    base = obs_idx;
    for (int i = 0; i < 5; i++) begin
      v[i] = $urandom;
      preload(16'h0700 + 16'(i), v[i]);
      exp_q.push_back(mk_ev(2'd1, 16'h0700 + 16'(i), 32'h0));
      exp_q.push_back(mk_ev(2'd2, 16'h0800 + 16'(i), v[i]));
      // Zero-length ch3 kick lands during the first word's RD; its done shows in the WR cycle
      if (i == 0) exp_q.push_back(mk_ev(2'd3, 16'h0, 32'h8));
    end
    exp_q.push_back(mk_ev(2'd3, 16'h0, 32'h1));
    do_kick(0, 16'h0700, 16'h0800, 16'd5, err0, kc);
    do_kick(0, 16'h0900, 16'h0980, 16'd2, err1, kc);
    do_kick(3, 16'h0A00, 16'h0A80, 16'd0, err3, kc);
    n_checks++;
    if (err0 !== 1'b0) begin n_fail++; $display("FAIL t4_first_err: got %b, required 0", err0); end
    n_checks++;
    if (err1 !== 1'b1) begin n_fail++; $display("FAIL t4_busy_err: got %b, required 1", err1); end
    n_checks++;
    if (err3 !== 1'b0) begin n_fail++; $display("FAIL t4_zero_err: got %b, required 0", err3); end
    wait_quiet(300, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL t4_timeout: got busy, required idle"); end
    n_checks++;
    if (busy_seen[3] !== 1'b0) begin
      n_fail++; $display("FAIL t4_busy3: got %b, required 0", busy_seen[3]);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_idx >= obs_ev.size()) begin
        n_fail++; $display("FAIL t4_seq: got nothing, required %h", e);
      end else begin
        if (obs_ev[obs_idx] !== e) begin
          n_fail++; $display("FAIL t4_seq[%0d]: got %h, required %h", obs_idx - base,
                             obs_ev[obs_idx], e);
        end
        obs_idx++;
      end
    end
    n_checks++;
    if (obs_idx != obs_ev.size()) begin
      n_fail++; $display("FAIL t4_extra: got %0d extra events, required 0", obs_ev.size() - obs_idx);
      obs_idx = obs_ev.size();
    end
  endtask

  task automatic test_addr_wrap();
    logic [31:0] v [4];
    logic [15:0] sa [4];
    logic [63:0] e;
    logic        err;
    int          kc, base;
    bit          ok;
    base = obs_idx;
    sa = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    for (int i = 0; i < 4; i++) begin
      v[i] = $urandom;
      preload(sa[i], v[i]);
      exp_q.push_back(mk_ev(2'd1, sa[i], 32'h0));
      exp_q.push_back(mk_ev(2'd2, 16'h0100 + 16'(i), v[i]));
    end
    exp_q.push_back(mk_ev(2'd3, 16'h0, 32'h1));
    do_kick(0, 16'hFFFE, 16'h0100, 16'd4, err, kc);
    wait_quiet(200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL t5_timeout: got busy, required idle"); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_idx >= obs_ev.size()) begin
        n_fail++; $display("FAIL t5_seq: got nothing, required %h", e);
      end else begin
        if (obs_ev[obs_idx] !== e) begin
          n_fail++; $display("FAIL t5_seq[%0d]: got %h, required %h", obs_idx - base,
                             obs_ev[obs_idx], e);
        end
        obs_idx++;
      end
    end
    n_checks++;
    if (obs_idx != obs_ev.size()) begin
      n_fail++; $display("FAIL t5_extra: got %0d extra events, required 0", obs_ev.size() - obs_idx);
      obs_idx = obs_ev.size();
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v [8];
    logic [31:0] w [2];
    logic [63:0] e;
    logic        err;
    int          kc, base, nwr;
    bit          ok;
    base = obs_idx;
    for (int i = 0; i < 8; i++) begin v[i] = $urandom; preload(16'h0B00 + 16'(i), v[i]); end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk_ev(2'd1, 16'h0B00 + 16'(i), 32'h0));
      if (i < 2) exp_q.push_back(mk_ev(2'd2, 16'h0C00 + 16'(i), v[i]));
    end
    do_kick(1, 16'h0B00, 16'h0C00, 16'd8, err, kc);
    nwr = 0;
    for (int i = 0; i < 60 && nwr < 3; i++) begin
      @(posedge clk); #1;
      if (bus.sram_en && bus.sram_we) nwr++;
    end
    n_checks++;
    if (nwr != 3) begin n_fail++; $display("FAIL t6_reach_wr: got %0d writes, required 3", nwr); end
    // Asserted mid-cycle in the third WR, away from any clock edge
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.sram_en, bus.sram_we, bus.kick_err, bus.any_busy} !== 4'b0) begin
      n_fail++; $display("FAIL t6_async_ctrl: got %b, required 0000",
                         {bus.sram_en, bus.sram_we, bus.kick_err, bus.any_busy});
    end
    n_checks++;
    if (bus.sram_addr !== 16'h0 || bus.sram_di !== 32'h0) begin
      n_fail++; $display("FAIL t6_async_bus: got %h/%h, required 0/0", bus.sram_addr, bus.sram_di);
    end
    n_checks++;
    if (bus.ch_busy !== 4'h0 || bus.ch_done !== 4'h0) begin
      n_fail++; $display("FAIL t6_async_ch: got %b/%b, required 0/0", bus.ch_busy, bus.ch_done);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      w[i] = $urandom;
      preload(16'h0D00 + 16'(i), w[i]);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_idx >= obs_ev.size()) begin
        n_fail++; $display("FAIL t6_seq: got nothing, required %h", e);
      end else begin
        if (obs_ev[obs_idx] !== e) begin
          n_fail++; $display("FAIL t6_seq[%0d]: got %h, required %h", obs_idx - base,
                             obs_ev[obs_idx], e);
        end
        obs_idx++;
      end
    end
    n_checks++;
    if (obs_idx != obs_ev.size()) begin
      n_fail++; $display("FAIL t6_after_reset: got %0d events, required 0", obs_ev.size() - obs_idx);
      obs_idx = obs_ev.size();
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk_ev(2'd1, 16'h0D00 + 16'(i), 32'h0));
      exp_q.push_back(mk_ev(2'd2, 16'h0D80 + 16'(i), w[i]));
    end
    exp_q.push_back(mk_ev(2'd3, 16'h0, 32'h2));
    do_kick(1, 16'h0D00, 16'h0D80, 16'd2, err, kc);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL t6_fresh_err: got %b, required 0", err); end
    wait_quiet(200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL t6_timeout: got busy, required idle"); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_idx >= obs_ev.size()) begin
        n_fail++; $display("FAIL t6_fresh_seq: got nothing, required %h", e);
      end else begin
        if (obs_ev[obs_idx] !== e) begin
          n_fail++; $display("FAIL t6_fresh_seq: got %h, required %h", obs_ev[obs_idx], e);
        end
        obs_idx++;
      end
    end
    n_checks++;
    if (obs_idx != obs_ev.size()) begin
      n_fail++; $display("FAIL t6_fresh_extra: got %0d extra events, required 0",
                         obs_ev.size() - obs_idx);
      obs_idx = obs_ev.size();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.kick      = 1'b0;
    bus.kick_ch   = '0;
    bus.kick_src  = '0;
    bus.kick_dst  = '0;
    bus.kick_size = '0;
    bus.mem_hold  = 1'b0;
    test_reset();
    test_single();
    test_two_channels();
    test_mem_hold();
    test_busy_and_zero();
    test_addr_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
